byte_ram: RTL and testbench
===========================

Name: byte_ram

Overview:
- Byte-addressed, word-organised data RAM with byte-lane writes and sub-word loads (byte/half/word/double) using sign or zero extension.
- Detects misaligned accesses and returns a fixed-latency response with an optional extra output register stage.
- Sits between the CPU load/store stage and on-chip storage.
- Replaces the whole-word-only RAM: adds byte enables, size/extension handling, fault reporting, a response valid and selectable read latency.

Parameters:
- ADDR_WIDTH, 12, byte address width; capacity is 2^ADDR_WIDTH bytes.
- DATA_WIDTH, 32, word width in bits; legal values are 32 and 64.
- READ_LATENCY, 1, cycles from request to response; legal values are 1 and 2 (2 adds an output register).
- Derived: LANES = DATA_WIDTH/8; OFS = log2(LANES); DEPTH = 2^(ADDR_WIDTH-OFS) words.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle; always accepted, no back-pressure.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0; ignored for stores.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, right-aligned (bits [8*2^size-1:0] are used).
- rsp_valid  out  1  response for the request accepted READ_LATENCY cycles earlier.
- rsp_rdata  out  DATA_WIDTH  load data, extended to full width; 0 for stores and faults.
- rsp_fault  out  1  request was misaligned or its size was illegal.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: rsp_valid = 0, rsp_fault = 0, rsp_rdata = 0, pipeline valids cleared. Memory contents are not reset (undefined until written).
- Reset mid-operation: a request accepted in the same cycle as rst, or still in flight, produces no response. A store accepted in a cycle with rst high does not write.
- Legality checks:
  - Size check: 2^req_size bytes must be at most LANES. req_size = 3 with DATA_WIDTH = 32 is a fault.
  - Alignment check: req_addr[req_size-1:0] must be 0. Byte accesses are never misaligned.
  - A faulting store does not modify memory. A faulting request still produces a response with rsp_fault = 1 and rsp_rdata = 0.
- Store (legal):
  - Lane mask = ((1<<2^size)-1) << addr[OFS-1:0].
  - Data is replicated or shifted into lanes by the same offset.
  - Only masked lanes of word addr[ADDR_WIDTH-1:OFS] are written, at the accepting edge.
  - Response: rsp_valid = 1, rsp_rdata = 0, rsp_fault = 0.
- Load (legal):
  - The word is read through a registered address, as synchronous BRAM.
  - The lane group is shifted down by the offset, then sign- or zero-extended from 8·2^size bits.
- Ordering:
  - One request per cycle.
  - A load accepted in cycle N sees every store accepted in cycles before N.
  - No same-cycle read/write collision is possible.
- Latency:
  - READ_LATENCY = 1: response signals are valid on the cycle after acceptance.
  - READ_LATENCY = 2: the formatted result is registered once more. Throughput stays 1 request/cycle.
- Outputs when rsp_valid = 0: rsp_rdata and rsp_fault are 0.
- Address wrap: none. The full ADDR_WIDTH space is backed, and the top word index DEPTH-1 is legal.

Decomposition:
- Shared package ram_pkg:
  - Size encodings SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3.
  - Function lane_mask(size, offset).
  - Function is_misaligned(size, addr_lsbs).
- Sub-module load_fmt: combinational; inputs are the raw word, offset, size and unsigned flag; output is the extended result. It is reused later by the cache refill path.
- Top byte_ram: storage array with per-lane write enables, request pipeline registers (valid, we, size, unsigned, offset, fault) and the optional output stage.

Test Plan:
- 32-bit, READ_LATENCY = 1: SW 0xDEADBEEF @0x10; LW @0x10 → next cycle rsp_valid = 1, rdata = 0xDEADBEEF, fault = 0.
- SB 0x80 @0x21 over word 0x00000000; LB @0x21 → 0xFFFFFF80; LBU @0x21 → 0x00000080; LW @0x20 → 0x00008000.
- SH 0x1234 @0x32; LH @0x32 → 0x00001234. SH @0x31 → rsp_fault = 1, rdata = 0, and a following LW @0x30 is unchanged.
- 64-bit, READ_LATENCY = 2: back-to-back SD 0x0123456789ABCDEF @0x8 then LD @0x8 → LD response 2 cycles after its request equals the stored value. LWU @0xC → 0x0000000001234567.
- Size 3 on 32-bit → fault. Assert rst while a load is in flight → no rsp_valid afterwards; all outputs 0 after the reset cycle.
- Streaming: 1 request/cycle for 16 cycles (mixed loads/stores, random addresses) → rsp_valid pattern equals the req_valid pattern delayed by READ_LATENCY; data matches the reference model.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the byte-addressed data RAM: access size encodings
// and the lane-mask / alignment helpers used by the store and load paths.
package ram_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    // Lane mask for up to 8 lanes; callers truncate to their own lane count.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << offset;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lsbs);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addr_lsbs[0];
            SZ_W:    mis = |addr_lsbs[1:0];
            default: mis = |addr_lsbs;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_fmt.sv
// Load formatter: moves the addressed lane group down to bit 0 and sign- or
// zero-extends it from the access width to the full word.
module load_fmt
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int OFS = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [OFS-1:0]        offset,
    input  logic [1:0]            size,
    input  logic                  uns,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] keep;
    logic [DATA_WIDTH-1:0] sign_bit;
    logic                  neg;

    always_comb begin
        sh   = word >> {offset, 3'b000};
        keep = '1;
        case (size)
            SZ_B:    keep = DATA_WIDTH'(8'hFF);
            SZ_H:    keep = DATA_WIDTH'(16'hFFFF);
            SZ_W:    keep = DATA_WIDTH'(32'hFFFF_FFFF);
            default: keep = '1;
        endcase
        // Top bit of the kept field, found without a variable bit index.
        sign_bit = keep ^ (keep >> 1);
        neg      = !uns && (|(sh & sign_bit));
        result   = (sh & keep) | (neg ? ~keep : '0);
    end

endmodule

// File: rtl/byte_ram.sv
// Byte-addressed data RAM with lane writes, sub-word loads, misalignment
// faults and a fixed 1- or 2-cycle response.
module byte_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(LANES);
    localparam int IW    = ADDR_WIDTH - OFS;
    localparam int DEPTH = 2 ** IW;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [OFS-1:0]        offset;
    logic [IW-1:0]         widx;
    logic [LANES-1:0]      mask;
    logic                  size_bad;
    logic                  fault;
    logic                  do_write;
    logic [DATA_WIDTH-1:0] wdata_sh;

    always_comb begin
        offset   = req_addr[OFS-1:0];
        widx     = req_addr[ADDR_WIDTH-1:OFS];
        size_bad = (LANES < 8) && (req_size == SZ_D);
        fault    = size_bad | is_misaligned(req_size, 3'(offset));
        mask     = LANES'(lane_mask(req_size, 3'(offset)));
        wdata_sh = req_wdata << {offset, 3'b000};
        do_write = req_valid && req_we && !fault && !rst;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < LANES; i++) begin
                if (mask[i]) mem[widx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
    end

    logic                  s1_valid;
    logic                  s1_we;
    logic [1:0]            s1_size;
    logic                  s1_uns;
    logic [OFS-1:0]        s1_ofs;
    logic                  s1_fault;
    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] fmt;

    // Only the valid bit needs reset; the payload is qualified by it.
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= req_valid;
        s1_we    <= req_we;
        s1_size  <= req_size;
        s1_uns   <= req_unsigned;
        s1_ofs   <= offset;
        s1_fault <= fault;
        rd_idx   <= widx;
    end

    assign rd_word = mem[rd_idx];

    load_fmt #(.DATA_WIDTH(DATA_WIDTH)) u_fmt (
        .word   (rd_word),
        .offset (s1_ofs),
        .size   (s1_size),
        .uns    (s1_uns),
        .result (fmt)
    );

    logic                  r1_valid;
    logic                  r1_fault;
    logic [DATA_WIDTH-1:0] r1_data;

    always_comb begin
        r1_valid = s1_valid;
        r1_fault = s1_valid && s1_fault;
        r1_data  = (s1_valid && !s1_we && !s1_fault) ? fmt : '0;
    end

    generate
        if (READ_LATENCY == 2) begin : g_out_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    rsp_valid <= 1'b0;
                    rsp_fault <= 1'b0;
                    rsp_rdata <= '0;
                end else begin
                    rsp_valid <= r1_valid;
                    rsp_fault <= r1_fault;
                    rsp_rdata <= r1_data;
                end
            end
        end else begin : g_out_comb
            assign rsp_valid = r1_valid;
            assign rsp_fault = r1_fault;
            assign rsp_rdata = r1_data;
        end
    endgenerate

endmodule

// File: tb/tb_byte_ram.sv
// Bench for byte_ram: a 32-bit/latency-1 and a 64-bit/latency-2 instance run
// side by side against a byte-array reference model.
module tb_byte_ram;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v32, we32, u32, rv32, rf32;
    logic [1:0]  sz32;
    logic [11:0] a32;
    logic [31:0] wd32, rd32;
    logic        v64, we64, u64, rv64, rf64;
    logic [1:0]  sz64;
    logic [11:0] a64;
    logic [63:0] wd64, rd64;

    byte_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .READ_LATENCY(1)) dut32 (
        .clk(clk), .rst(rst), .req_valid(v32), .req_we(we32), .req_size(sz32),
        .req_unsigned(u32), .req_addr(a32), .req_wdata(wd32),
        .rsp_valid(rv32), .rsp_rdata(rd32), .rsp_fault(rf32)
    );

    byte_ram #(.ADDR_WIDTH(12), .DATA_WIDTH(64), .READ_LATENCY(2)) dut64 (
        .clk(clk), .rst(rst), .req_valid(v64), .req_we(we64), .req_size(sz64),
        .req_unsigned(u64), .req_addr(a64), .req_wdata(wd64),
        .rsp_valid(rv64), .rsp_rdata(rd64), .rsp_fault(rf64)
    );

    typedef struct {
        bit        v;
        bit        we;
        bit [1:0]  sz;
        bit        uns;
        bit [11:0] a;
        bit [63:0] wd;
    } req_t;

    typedef struct {
        bit        v;
        bit        f;
        bit [63:0] d;
    } rsp_t;

    int ncomp = 0;
    int nfail = 0;

    logic [7:0] mem32 [0:4095];
    logic [7:0] mem64 [0:4095];

    req_t IDLE_REQ = '{v: 1'b0, we: 1'b0, sz: 2'd0, uns: 1'b0, a: 12'd0, wd: 64'd0};
    rsp_t IDLE_RSP = '{v: 1'b0, f: 1'b0, d: 64'd0};
    req_t q32, q64;
    rsp_t e32, p64, o64;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(bit we, bit [1:0] sz, bit uns, bit [11:0] a, bit [63:0] wd);
        return '{v: 1'b1, we: we, sz: sz, uns: uns, a: a, wd: wd};
    endfunction

    function automatic req_t rnd(bit force_v);
        req_t r;
        r.v   = force_v || ($urandom_range(0, 2) != 0);
        r.we  = 1'($urandom_range(0, 1));
        r.sz  = 2'($urandom_range(0, 3));
        r.uns = 1'($urandom_range(0, 1));
        r.a   = 12'($urandom_range(0, 255));
        r.wd  = {$urandom, $urandom};
        return r;
    endfunction

    // Byte-level little-endian memory: legality, store, then load + extension.
    function automatic rsp_t model(input bit is64, input req_t r);
        rsp_t      s;
        int        nb;
        logic [63:0] val;
        logic [7:0]  b;
        s = IDLE_RSP;
        if (!r.v) return s;
        s.v = 1'b1;
        nb  = 1 << r.sz;
        if (nb > (is64 ? 8 : 4) || (int'(r.a) % nb) != 0) begin
            s.f = 1'b1;
            return s;
        end
        if (r.we) begin
            for (int i = 0; i < nb; i++) begin
                b = 8'(r.wd >> (8 * i));
                if (is64) mem64[int'(r.a) + i] = b;
                else      mem32[int'(r.a) + i] = b;
            end
            return s;
        end
        val = 64'd0;
        for (int i = 0; i < nb; i++) begin
            b   = is64 ? mem64[int'(r.a) + i] : mem32[int'(r.a) + i];
            val = val | (64'(b) << (8 * i));
        end
        if (!r.uns && ((val >> (8 * nb - 1)) & 64'd1) != 64'd0)
            val = val | ~((64'd1 << (8 * nb)) - 64'd1);
        if (!is64) val = val & 64'hFFFF_FFFF;
        s.d = val;
        return s;
    endfunction

    // One clock: drive both requests, advance, compare both response ports.
    task automatic cyc();
        rsp_t n32, n64;
        v32 = q32.v; we32 = q32.we; sz32 = q32.sz; u32 = q32.uns; a32 = q32.a; wd32 = q32.wd[31:0];
        v64 = q64.v; we64 = q64.we; sz64 = q64.sz; u64 = q64.uns; a64 = q64.a; wd64 = q64.wd;
        n32 = rst ? IDLE_RSP : model(1'b0, q32);
        n64 = rst ? IDLE_RSP : model(1'b1, q64);
        @(posedge clk);
        #1;
        e32 = n32;
        o64 = rst ? IDLE_RSP : p64;
        p64 = n64;
        chk("valid32", 64'(rv32), 64'(e32.v));
        chk("fault32", 64'(rf32), 64'(e32.f));
        chk("rdata32", 64'(rd32), e32.d);
        chk("valid64", 64'(rv64), 64'(o64.v));
        chk("fault64", 64'(rf64), 64'(o64.f));
        chk("rdata64", rd64, o64.d);
        q32 = IDLE_REQ;
        q64 = IDLE_REQ;
    endtask

    initial begin
        q32 = IDLE_REQ;
        q64 = IDLE_REQ;
        p64 = IDLE_RSP;
        rst = 1'b1;
        cyc();
        cyc();
        chk("reset_v32", 64'(rv32), 64'd0);
        chk("reset_d64", rd64, 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 64; k++) begin
            q32 = mk(1'b1, 2'd2, 1'b0, 12'(4 * k), {32'd0, $urandom});
            if (k < 32) q64 = mk(1'b1, 2'd3, 1'b0, 12'(8 * k), {$urandom, $urandom});
            cyc();
        end

        // Top word of the address space.
        q32 = mk(1'b1, 2'd2, 1'b0, 12'hFFC, 64'hCAFE_F00D);
        q64 = mk(1'b1, 2'd3, 1'b0, 12'hFF8, 64'h1122_3344_5566_7788);
        cyc();
        q32 = mk(1'b0, 2'd2, 1'b0, 12'hFFC, 64'd0);
        q64 = mk(1'b0, 2'd3, 1'b0, 12'hFF8, 64'd0);
        cyc();
        chk("top32", 64'(rd32), 64'hCAFE_F00D);
        cyc();
        chk("top64", rd64, 64'h1122_3344_5566_7788);

        q32 = mk(1'b1, 2'd2, 1'b0, 12'h010, 64'hDEAD_BEEF); cyc();
        q32 = mk(1'b0, 2'd2, 1'b0, 12'h010, 64'd0);         cyc();
        chk("lw_10", 64'(rd32), 64'hDEAD_BEEF);
        chk("lw_10_valid", 64'(rv32), 64'd1);

        q32 = mk(1'b1, 2'd2, 1'b0, 12'h020, 64'd0);  cyc();
        q32 = mk(1'b1, 2'd0, 1'b0, 12'h021, 64'h80); cyc();
        q32 = mk(1'b0, 2'd0, 1'b0, 12'h021, 64'd0);  cyc();
        chk("lb_21", 64'(rd32), 64'hFFFF_FF80);
        q32 = mk(1'b0, 2'd0, 1'b1, 12'h021, 64'd0);  cyc();
        chk("lbu_21", 64'(rd32), 64'h0000_0080);
        q32 = mk(1'b0, 2'd2, 1'b0, 12'h020, 64'd0);  cyc();
        chk("lw_20", 64'(rd32), 64'h0000_8000);

        q32 = mk(1'b1, 2'd2, 1'b0, 12'h030, 64'hA5A5_5A5A); cyc();
        q32 = mk(1'b1, 2'd1, 1'b0, 12'h032, 64'h1234);      cyc();
        q32 = mk(1'b0, 2'd1, 1'b0, 12'h032, 64'd0);         cyc();
        chk("lh_32", 64'(rd32), 64'h0000_1234);
        q32 = mk(1'b1, 2'd1, 1'b0, 12'h031, 64'hFFFF);      cyc();
        chk("sh_31_fault", 64'(rf32), 64'd1);
        chk("sh_31_rdata", 64'(rd32), 64'd0);
        q32 = mk(1'b0, 2'd2, 1'b0, 12'h030, 64'd0);         cyc();
        chk("lw_30", 64'(rd32), 64'h1234_5A5A);

        q32 = mk(1'b0, 2'd3, 1'b0, 12'h010, 64'd0); cyc();
        chk("size3_fault32", 64'(rf32), 64'd1);

        // Request accepted with reset high: no response, and no write.
        rst = 1'b1;
        q32 = mk(1'b0, 2'd2, 1'b0, 12'h010, 64'd0); cyc();
        chk("rst_load_v32", 64'(rv32), 64'd0);
        q32 = mk(1'b1, 2'd2, 1'b0, 12'h010, 64'h1111_1111); cyc();
        rst = 1'b0;
        q32 = mk(1'b0, 2'd2, 1'b0, 12'h010, 64'd0); cyc();
        chk("rst_store_blocked", 64'(rd32), 64'hDEAD_BEEF);

        q64 = mk(1'b1, 2'd3, 1'b0, 12'h008, 64'h0123_4567_89AB_CDEF); cyc();
        q64 = mk(1'b0, 2'd3, 1'b0, 12'h008, 64'd0);                   cyc();
        chk("sd_rsp_valid", 64'(rv64), 64'd1);
        q64 = mk(1'b0, 2'd2, 1'b1, 12'h00C, 64'd0);                   cyc();
        chk("ld_08", rd64, 64'h0123_4567_89AB_CDEF);
        q64 = mk(1'b0, 2'd2, 1'b0, 12'h008, 64'd0);                   cyc();
        chk("lwu_0c", rd64, 64'h0000_0000_0123_4567);
        cyc();
        chk("lw_08_sext", rd64, 64'hFFFF_FFFF_89AB_CDEF);

        // Reset while a 64-bit load sits in the pipeline.
        q64 = mk(1'b0, 2'd3, 1'b0, 12'h008, 64'd0); cyc();
        rst = 1'b1;
        cyc();
        chk("rst_inflight_v64", 64'(rv64), 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_v64", 64'(rv64), 64'd0);
        chk("post_rst_d64", rd64, 64'd0);

        for (int n = 0; n < 16; n++) begin
            q32 = rnd(1'b1);
            q64 = rnd(1'b1);
            cyc();
        end
        for (int n = 0; n < 48; n++) begin
            q32 = rnd(1'b0);
            q64 = rnd(1'b0);
            cyc();
        end
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
